// File: rtl/shop_inv_v.sv
// shop_inv_v: token-driven shop inventory with user login, user admin, item stock and purchases.
module shop_inv_v #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int O_A_NUM_ASCII_CHARS = 9,
    parameter int I_U_NUM_BITS = 4,
    parameter int MAX_USERS = 5,
    parameter int MAX_ITEMS = 4,
    parameter int STOCK_BITS = 8,
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] ADMIN_USERNAME = (I_A_NUM_ASCII_CHARS*8)'("Adm"),
    parameter logic [I_A_NUM_ASCII_CHARS*8-1:0] ADMIN_PASSWORD = (I_A_NUM_ASCII_CHARS*8)'("123")
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_rdy,
    input  logic [I_U_NUM_BITS-1:0]          i_u,
    input  logic [I_A_NUM_ASCII_CHARS*8-1:0] i_a,
    output logic [O_A_NUM_ASCII_CHARS*8-1:0] o_a,
    output logic                             o_valid
);
    localparam int IW = I_A_NUM_ASCII_CHARS * 8;
    localparam int OW = O_A_NUM_ASCII_CHARS * 8;
    localparam int SB = STOCK_BITS;
    localparam int UW = MAX_USERS > 1 ? $clog2(MAX_USERS) : 1;
    localparam int TW = MAX_ITEMS > 1 ? $clog2(MAX_ITEMS) : 1;
    localparam logic [IW-1:0] K_LOGIN = IW'("Login"), K_LOGOUT = IW'("Logout"), K_ADDUSR = IW'("AddUsr"),
        K_DELUSR = IW'("DelUsr"), K_ADDITEM = IW'("AddItem"), K_DELITEM = IW'("DelItem"), K_BUY = IW'("Buy");
    localparam logic [OW-1:0] S_CMD = OW'("Cmd?"), S_USER = OW'("Username?"), S_PASS = OW'("Password?"),
        S_PERMS = OW'("Perms?"), S_ITEM = OW'("Item?"), S_OK = OW'("Ok"), S_INVCMD = OW'("InvalCmd"),
        S_INVPERM = OW'("InvalPerm"), S_UNKUSER = OW'("UnkUser"), S_BADPASS = OW'("BadPass"),
        S_UFULL = OW'("UsrFull"), S_UTAKEN = OW'("UsrTaken"), S_IFULL = OW'("ItmFull"),
        S_UNKITEM = OW'("UnkItem"), S_INVQTY = OW'("InvalQty"), S_NOSTOCK = OW'("NoStock");

    typedef enum logic [3:0] {
        CMD, LOG_USER, LOG_PASS, NEW_USER, NEW_PASS, NEW_PERM, DEL_USER, ITEM_ADD, ITEM_DEL, ITEM_BUY
    } state_t;

    state_t                  r_state;
    logic                    r_rdy_d, r_go, r_logged;
    logic [UW-1:0]           r_cur, r_lidx;
    logic [IW-1:0]           r_a_l, r_nname, r_npass;
    logic [I_U_NUM_BITS-1:0] r_u_l;
    logic [MAX_USERS-1:0]    r_uused, r_uperm;
    logic [IW-1:0]           r_uname [MAX_USERS];
    logic [IW-1:0]           r_upass [MAX_USERS];
    logic [MAX_ITEMS-1:0]    r_iused;
    logic [IW-1:0]           r_iname [MAX_ITEMS];
    logic [SB-1:0]           r_istock [MAX_ITEMS];

    logic          w_uhit, w_ufree, w_ihit, w_ifree, w_admin, w_rise;
    logic [UW-1:0] w_uidx, w_ufidx;
    logic [TW-1:0] w_iidx, w_ifidx;
    logic [SB:0]   w_sum, w_qty;

    // Descending scans so the lowest matching or free slot wins.
    always_comb begin
        w_uhit = 1'b0;
        w_uidx = '0;
        w_ufree = 1'b0;
        w_ufidx = '0;
        for (int k = MAX_USERS - 1; k >= 0; k--) begin
            if (r_uused[k] && r_uname[k] == r_a_l) begin
                w_uhit = 1'b1;
                w_uidx = UW'(k);
            end
            if (!r_uused[k]) begin
                w_ufree = 1'b1;
                w_ufidx = UW'(k);
            end
        end
        w_ihit = 1'b0;
        w_iidx = '0;
        w_ifree = 1'b0;
        w_ifidx = '0;
        for (int k = MAX_ITEMS - 1; k >= 0; k--) begin
            if (r_iused[k] && r_iname[k] == r_a_l) begin
                w_ihit = 1'b1;
                w_iidx = TW'(k);
            end
            if (!r_iused[k]) begin
                w_ifree = 1'b1;
                w_ifidx = TW'(k);
            end
        end
    end

    assign w_admin = r_logged && r_uperm[r_cur];
    assign w_rise  = i_rdy && !r_rdy_d;
    assign w_qty   = (SB+1)'(r_u_l);
    assign w_sum   = (SB+1)'(r_istock[w_iidx]) + w_qty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdy_d  <= 1'b0;
            r_go     <= 1'b0;
            r_state  <= CMD;
            r_logged <= 1'b0;
            r_cur    <= '0;
            o_a      <= S_CMD;
            o_valid  <= 1'b0;
            r_uused  <= MAX_USERS'(1);
            r_uperm  <= MAX_USERS'(1);
            r_iused  <= '0;
            for (int k = 0; k < MAX_USERS; k++) begin
                r_uname[k] <= k == 0 ? ADMIN_USERNAME : '0;
                r_upass[k] <= k == 0 ? ADMIN_PASSWORD : '0;
            end
            for (int k = 0; k < MAX_ITEMS; k++) begin
                r_iname[k]  <= '0;
                r_istock[k] <= '0;
            end
        end else begin
            r_rdy_d <= i_rdy;
            r_go    <= w_rise;
            o_valid <= r_go;
            if (w_rise) begin
                r_a_l <= i_a;
                r_u_l <= i_u;
            end
            if (r_go) begin
                r_state <= CMD;
                case (r_state)
                    CMD: begin
                        if (r_a_l == K_LOGIN) begin
                            o_a     <= r_logged ? S_INVPERM : S_USER;
                            r_state <= r_logged ? CMD : LOG_USER;
                        end else if (r_a_l == K_LOGOUT) begin
                            o_a      <= r_logged ? S_CMD : S_INVPERM;
                            r_logged <= 1'b0;
                        end else if (r_a_l == K_BUY) begin
                            o_a     <= r_logged ? S_ITEM : S_INVPERM;
                            r_state <= r_logged ? ITEM_BUY : CMD;
                        end else if (r_a_l == K_ADDUSR) begin
                            o_a     <= !w_admin ? S_INVPERM : w_ufree ? S_USER : S_UFULL;
                            r_state <= w_admin && w_ufree ? NEW_USER : CMD;
                        end else if (r_a_l == K_DELUSR) begin
                            o_a     <= w_admin ? S_USER : S_INVPERM;
                            r_state <= w_admin ? DEL_USER : CMD;
                        end else if (r_a_l == K_ADDITEM || r_a_l == K_DELITEM) begin
                            o_a     <= w_admin ? S_ITEM : S_INVPERM;
                            r_state <= !w_admin ? CMD : r_a_l == K_ADDITEM ? ITEM_ADD : ITEM_DEL;
                        end else begin
                            o_a <= S_INVCMD;
                        end
                    end
                    LOG_USER: begin
                        o_a     <= w_uhit ? S_PASS : S_UNKUSER;
                        r_state <= w_uhit ? LOG_PASS : CMD;
                        r_lidx  <= w_uidx;
                    end
                    LOG_PASS: begin
                        o_a      <= r_a_l == r_upass[r_lidx] ? S_CMD : S_BADPASS;
                        r_logged <= r_a_l == r_upass[r_lidx];
                        r_cur    <= r_lidx;
                    end
                    NEW_USER: begin
                        o_a     <= w_uhit ? S_UTAKEN : S_PASS;
                        r_state <= w_uhit ? CMD : NEW_PASS;
                        r_nname <= r_a_l;
                    end
                    NEW_PASS: begin
                        o_a     <= S_PERMS;
                        r_state <= NEW_PERM;
                        r_npass <= r_a_l;
                    end
                    NEW_PERM: begin
                        o_a <= S_OK;
                        r_uused[w_ufidx] <= 1'b1;
                        r_uperm[w_ufidx] <= r_u_l[0];
                        r_uname[w_ufidx] <= r_nname;
                        r_upass[w_ufidx] <= r_npass;
                    end
                    DEL_USER: begin
                        o_a <= !w_uhit ? S_UNKUSER : (w_uidx == '0 || w_uidx == r_cur) ? S_INVPERM : S_OK;
                        if (w_uhit && w_uidx != '0 && w_uidx != r_cur) r_uused[w_uidx] <= 1'b0;
                    end
                    ITEM_ADD: begin
                        o_a <= w_ihit || w_ifree ? S_OK : S_IFULL;
                        if (w_ihit) begin
                            r_istock[w_iidx] <= w_sum[SB] ? '1 : w_sum[SB-1:0];
                        end else if (w_ifree) begin
                            r_iused[w_ifidx]  <= 1'b1;
                            r_iname[w_ifidx]  <= r_a_l;
                            r_istock[w_ifidx] <= SB'(r_u_l);
                        end
                    end
                    ITEM_DEL: begin
                        o_a <= w_ihit ? S_OK : S_UNKITEM;
                        if (w_ihit) r_iused[w_iidx] <= 1'b0;
                    end
                    ITEM_BUY: begin
                        o_a <= !w_ihit ? S_UNKITEM : r_u_l == '0 ? S_INVQTY :
                               w_qty > (SB+1)'(r_istock[w_iidx]) ? S_NOSTOCK : S_OK;
                        if (w_ihit && r_u_l != '0 && w_qty <= (SB+1)'(r_istock[w_iidx]))
                            r_istock[w_iidx] <= r_istock[w_iidx] - SB'(r_u_l);
                    end
                    default: o_a <= S_INVCMD;
                endcase
            end
        end
    end
endmodule
